// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: buffers {error, data} frames,
// presents them first-word-fall-through, and tracks overflow and frame errors.
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int DROP_ERRORED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_error,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_error,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [7:0]              err_count,
  input  logic                    stat_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_evt;
  logic          err_evt;
  logic          full_w;
  logic          empty_w;
  logic [DATA_WIDTH:0] head;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push_req = in_valid && !((DROP_ERRORED != 0) && in_error);
  assign pop      = !empty_w && out_ready;
  assign push     = push_req && (!full_w || pop);
  assign ovf_evt  = push_req && full_w && !pop;
  assign err_evt  = in_valid && in_error;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Status events take priority over a coincident clear.
  always_comb begin
    overflow_d  = overflow_q;
    err_count_d = err_count_q;
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end else if (stat_clr) begin
      overflow_d = 1'b0;
    end
    if (err_evt) begin
      if (stat_clr) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (stat_clr) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_error, in_data};
    end
  end

  assign head      = mem[rd_ptr_q];
  assign out_valid = !empty_w;
  assign out_data  = empty_w ? '0 : head[DATA_WIDTH-1:0];
  assign out_error = empty_w ? 1'b0 : head[DATA_WIDTH];
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign err_count = err_count_q;

endmodule
